pc_next_ctrl: RTL and testbench

- Multi-cycle sequencing and next-address unit that drives the PC register's write enable and new-address inputs.
- Consumes the current PC and the fetched instruction word.
- Walks each instruction through IF/ID/EXE/MEM/WB and asserts PCWre exactly once per retired instruction, with the correct sequential, branch, jump or register target on NewAdd.

---
 rtl/pc_next_ctrl_if.sv | 25 ++
 rtl/pc_next_ctrl.sv | 137 +++++++++++++
 tb/tb_pc_next_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pc_next_ctrl_if.sv
// Bundles the PC-sequencer handshake: fetch/data-memory status and PC inputs,
// plus the PC write strobe, next address and FSM status.
interface pc_next_ctrl_if;
  logic [31:0] CurrentAdd;
  logic [31:0] Instr;
  logic        ImemRdy;
  logic        DmemRdy;
  logic        Zero;
  logic [31:0] RsData;
  logic        PCWre;
  logic [31:0] NewAdd;
  logic        IRWre;
  logic [2:0]  State;
  logic        Halted;

  modport master (
    output CurrentAdd, Instr, ImemRdy, DmemRdy, Zero, RsData,
    input  PCWre, NewAdd, IRWre, State, Halted
  );

  modport slave (
    input  CurrentAdd, Instr, ImemRdy, DmemRdy, Zero, RsData,
    output PCWre, NewAdd, IRWre, State, Halted
  );
endinterface

// File: rtl/pc_next_ctrl.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer that strobes the PC once per retired
// instruction and selects the sequential, branch, jump or register target.
module pc_next_ctrl #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP    = 6'b111111
) (
  input logic           CLK,
  input logic           Reset,
  pc_next_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t      state;
  logic [31:0] ir;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic        is_jr;
  logic        is_jump;
  logic        is_branch;
  logic        is_lw;
  logic        is_sw;
  logic        is_halt;
  logic        taken;
  logic [31:0] pc4;

  // Sign-extended word offset added to the already-incremented PC.
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] imm);
    logic signed [31:0] offset;
    offset = {{14{imm[15]}}, imm, 2'b00};
    return pc_plus4 + offset;
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction

  assign op        = ir[31:26];
  assign funct     = ir[5:0];
  assign is_jr     = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_jump   = (op == OP_J) || (op == OP_JAL) || is_jr;
  assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
  assign is_lw     = (op == OP_LW);
  assign is_sw     = (op == OP_SW);
  assign is_halt   = (op == HALT_OP);
  assign taken     = (op == OP_BEQ) ? bus.Zero : !bus.Zero;
  assign pc4       = bus.CurrentAdd + 32'd4;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= S_IF;
      ir    <= '0;
    end else begin
      case (state)
        S_IF: begin
          if (bus.ImemRdy) begin
            ir    <= bus.Instr;
            state <= S_ID;
          end
        end
        S_ID: begin
          if (is_jump)      state <= S_IF;
          else if (is_halt) state <= S_HALT;
          else              state <= S_EXE;
        end
        S_EXE: begin
          if (is_branch)            state <= S_IF;
          else if (is_lw || is_sw)  state <= S_MEM;
          else                      state <= S_WB;
        end
        S_MEM: begin
          if (bus.DmemRdy) state <= is_sw ? S_IF : S_WB;
        end
        S_WB:    state <= S_IF;
        S_HALT:  state <= S_HALT;
        default: state <= S_IF;
      endcase
    end
  end

  // Strobes are decoded from the state register so the single PCWre pulse
  // always lands in the instruction's final state.
  always_comb begin
    bus.PCWre  = 1'b0;
    bus.IRWre  = 1'b0;
    bus.Halted = 1'b0;
    bus.NewAdd = pc4;
    if (Reset) begin
      bus.NewAdd = RESET_ADDR;
    end else begin
      case (state)
        S_IF: bus.IRWre = bus.ImemRdy;
        S_ID: begin
          if (is_jump) begin
            bus.PCWre  = 1'b1;
            bus.NewAdd = is_jr ? bus.RsData : jump_target(pc4, ir[25:0]);
          end
        end
        S_EXE: begin
          if (is_branch) begin
            bus.PCWre = 1'b1;
            if (taken) bus.NewAdd = branch_target(pc4, ir[15:0]);
          end
        end
        S_MEM:  bus.PCWre = is_sw && bus.DmemRdy;
        S_WB:   bus.PCWre = 1'b1;
        S_HALT: begin
          bus.Halted = 1'b1;
          bus.NewAdd = RESET_ADDR;
        end
        default: ;
      endcase
    end
  end

  assign bus.State = state;

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Directed-vector bench for pc_next_ctrl: per-instruction latency, PC target,
// stalls, reset abort and halt behaviour.
module tb_pc_next_ctrl;

  localparam logic [31:0] RST_A = 32'hBFC0_0000;

  logic CLK = 1'b0;
  logic Reset;

  pc_next_ctrl_if ifc ();

  pc_next_ctrl #(.RESET_ADDR(RST_A), .HALT_OP(6'b111111)) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (ifc.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] cur;
    logic [31:0] rs;
    logic        zero;
    int          wait_n;
    int          cycles;
    logic [2:0]  fstate;
    logic [31:0] na;
  } vec_t;

  vec_t tbl[15];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] cur,
                              input logic [31:0] rs, input logic zero, input int wait_n,
                              input int cycles, input logic [2:0] fstate,
                              input logic [31:0] na);
    vec_t v;
    v.instr = instr; v.cur = cur; v.rs = rs; v.zero = zero; v.wait_n = wait_n;
    v.cycles = cycles; v.fstate = fstate; v.na = na;
    return v;
  endfunction

  // Entered shortly after a falling edge with the DUT sitting in IF.
  task automatic run(input vec_t v, input string tag);
    int          cyc  = 0;
    int          mcnt = 0;
    logic [2:0]  st   = 3'd0;
    logic [31:0] na   = 32'd0;
    logic        irw;
    ifc.Instr      = v.instr;
    ifc.CurrentAdd = v.cur;
    ifc.RsData     = v.rs;
    ifc.Zero       = v.zero;
    ifc.ImemRdy    = 1'b1;
    ifc.DmemRdy    = 1'b0;
    #1;
    irw = ifc.IRWre;
    for (int c = 1; c <= 16 && cyc == 0; c++) begin
      if (c > 1) begin
        @(negedge CLK);
        ifc.ImemRdy = 1'b0;
        if (ifc.State == 3'd3) begin
          ifc.DmemRdy = (mcnt >= v.wait_n);
          mcnt++;
        end else begin
          ifc.DmemRdy = 1'b0;
        end
        #1;
      end
      if (ifc.PCWre) begin
        cyc = c;
        st  = ifc.State;
        na  = ifc.NewAdd;
      end
    end
    check({tag, " irwre"}, 32'(irw), 32'd1);
    check({tag, " cycles"}, cyc, v.cycles);
    check({tag, " final_state"}, 32'(st), 32'(v.fstate));
    check({tag, " newadd"}, na, v.na);
    @(negedge CLK);
    ifc.DmemRdy = 1'b0;
    #1;
    check({tag, " back_to_if"}, 32'(ifc.State), 32'd0);
    check({tag, " no_extra_pcwre"}, 32'(ifc.PCWre), 32'd0);
  endtask

  initial begin
    int pc_seen;

    tbl[0]  = mk(32'h0000_0020, 32'h0000_0000, 32'h0, 1'b0, 0, 4, 3'd4, 32'h0000_0004);
    tbl[1]  = mk(32'h1000_FFFF, 32'h0000_0100, 32'h0, 1'b1, 0, 3, 3'd2, 32'h0000_0100);
    tbl[2]  = mk(32'h1000_FFFF, 32'h0000_0100, 32'h0, 1'b0, 0, 3, 3'd2, 32'h0000_0104);
    tbl[3]  = mk(32'h1400_0004, 32'h0000_0200, 32'h0, 1'b0, 0, 3, 3'd2, 32'h0000_0214);
    tbl[4]  = mk(32'h1400_0004, 32'h0000_0200, 32'h0, 1'b1, 0, 3, 3'd2, 32'h0000_0204);
    tbl[5]  = mk(32'h0800_0040, 32'hF000_0010, 32'h0, 1'b0, 0, 2, 3'd1, 32'hF000_0100);
    tbl[6]  = mk(32'h0C00_0010, 32'h0000_1000, 32'h0, 1'b0, 0, 2, 3'd1, 32'h0000_0040);
    tbl[7]  = mk(32'h03E0_0008, 32'h0000_0080, 32'h0000_2468, 1'b0, 0, 2, 3'd1, 32'h0000_2468);
    tbl[8]  = mk(32'hAC00_0000, 32'h0000_0010, 32'h0, 1'b0, 0, 4, 3'd3, 32'h0000_0014);
    tbl[9]  = mk(32'h8C00_0000, 32'h0000_0020, 32'h0, 1'b0, 0, 5, 3'd4, 32'h0000_0024);
    tbl[10] = mk(32'h8C00_0000, 32'h0000_0020, 32'h0, 1'b0, 3, 8, 3'd4, 32'h0000_0024);
    tbl[11] = mk(32'hAC00_0000, 32'h0000_0030, 32'h0, 1'b0, 2, 6, 3'd3, 32'h0000_0034);
    tbl[12] = mk(32'h2000_0000, 32'hFFFF_FFFC, 32'h0, 1'b0, 0, 4, 3'd4, 32'h0000_0000);
    tbl[13] = mk(32'h5800_0000, 32'h0000_0040, 32'h0, 1'b0, 0, 4, 3'd4, 32'h0000_0044);
    tbl[14] = mk(32'h1000_0010, 32'h7FFF_FFF0, 32'h0, 1'b1, 0, 3, 3'd2, 32'h8000_0034);

    // Reset state, with a ready fetch presented that must be ignored
    Reset = 1'b1;
    ifc.Instr = 32'h0000_0020; ifc.CurrentAdd = 32'h0; ifc.RsData = 32'h0;
    ifc.Zero = 1'b0; ifc.ImemRdy = 1'b1; ifc.DmemRdy = 1'b0;
    #1;
    check("reset state", 32'(ifc.State), 32'd0);
    check("reset pcwre", 32'(ifc.PCWre), 32'd0);
    check("reset irwre", 32'(ifc.IRWre), 32'd0);
    check("reset halted", 32'(ifc.Halted), 32'd0);
    check("reset newadd", ifc.NewAdd, RST_A);
    @(negedge CLK); @(negedge CLK);
    Reset = 1'b0;

    // Reset mid-EXE abandons the instruction without a PCWre pulse
    ifc.ImemRdy = 1'b1;
    @(negedge CLK); ifc.ImemRdy = 1'b0;
    @(negedge CLK); #1;
    check("midexe state", 32'(ifc.State), 32'd2);
    Reset = 1'b1;
    #1;
    check("midexe reset state", 32'(ifc.State), 32'd0);
    check("midexe reset pcwre", 32'(ifc.PCWre), 32'd0);
    check("midexe reset newadd", ifc.NewAdd, RST_A);
    @(negedge CLK);
    Reset = 1'b0;
    run(tbl[0], "after_reset_add");

    for (int i = 0; i < 15; i++) run(tbl[i], $sformatf("vec%0d", i));

    // Fetch stall: nothing is latched until ImemRdy rises
    ifc.Instr = 32'h8C00_0000; ifc.ImemRdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK); #1;
      check($sformatf("stall%0d state", k), 32'(ifc.State), 32'd0);
      check($sformatf("stall%0d irwre", k), 32'(ifc.IRWre), 32'd0);
    end
    run(tbl[5], "after_stall_j");

    // HALT is absorbing until reset
    ifc.Instr = 32'hFC00_0000; ifc.ImemRdy = 1'b1;
    pc_seen = 0;
    for (int k = 0; k < 22; k++) begin
      @(negedge CLK); #1;
      if (ifc.PCWre) pc_seen++;
    end
    check("halt state", 32'(ifc.State), 32'd5);
    check("halt halted", 32'(ifc.Halted), 32'd1);
    check("halt newadd", ifc.NewAdd, RST_A);
    check("halt pcwre count", pc_seen, 32'd0);
    Reset = 1'b1;
    @(negedge CLK); #1;
    check("unhalt state", 32'(ifc.State), 32'd0);
    check("unhalt halted", 32'(ifc.Halted), 32'd0);
    Reset = 1'b0;
    ifc.ImemRdy = 1'b0;
    @(negedge CLK);
    run(tbl[12], "after_halt_wrap");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
